// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: XOR edge detectors on N level inputs set per-channel pending
// flags, which a round-robin IDLE/BUSY scheduler serves one at a time on a valid/ready port.
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    in_i,
    input  logic            clr_ovf_i,
    input  logic            evt_ready_i,
    output logic            evt_valid_o,
    output logic [IDW-1:0]  evt_id_o,
    output logic            evt_level_o,
    output logic [N-1:0]    pending_o,
    output logic [N-1:0]    ovf_o,
    output logic [CNTW-1:0] evt_cnt_o
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    in_dly_q;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    ovf_q, ovf_d;
    logic [IDW-1:0]  evt_id_q, evt_id_d;
    logic            evt_level_q, evt_level_d;
    logic [CNTW-1:0] evt_cnt_q, evt_cnt_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [N-1:0]    edge_w;
    logic [N-1:0]    clr_w;
    logic [N-1:0]    ovf_set_w;
    logic            accept_w;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [IDW:0]    cand_sum;

    assign accept_w = (state_q == S_BUSY) && evt_ready_i;

    // An edge landing on the channel being accepted re-arms it instead of overflowing.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign edge_w[gi]    = in_i[gi] ^ in_dly_q[gi];
        assign clr_w[gi]     = accept_w && (evt_id_q == IDW'(gi));
        assign ovf_set_w[gi] = edge_w[gi] && pending_q[gi] && !clr_w[gi];
        assign pending_d[gi] = (pending_q[gi] && !clr_w[gi]) || edge_w[gi];
        assign ovf_d[gi]     = ovf_set_w[gi] || (ovf_q[gi] && !clr_ovf_i);
    end

    // First pending channel at or after rr_ptr, wrapping modulo N.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_sum    = '0;
        for (int k = 0; k < N; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(N)) begin
                cand_sum = cand_sum - (IDW+1)'(N);
            end
            if (!grant_found && pending_q[cand_sum[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        evt_id_d    = evt_id_q;
        evt_level_d = evt_level_q;
        evt_cnt_d   = evt_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d     = S_BUSY;
                    evt_id_d    = grant_id;
                    evt_level_d = in_i[grant_id];
                end
            end
            S_BUSY: begin
                if (evt_ready_i) begin
                    state_d   = S_IDLE;
                    evt_cnt_d = evt_cnt_q + CNTW'(1);
                    rr_ptr_d  = (evt_id_q == IDW'(N-1)) ? '0 : evt_id_q + IDW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            in_dly_q    <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            evt_id_q    <= '0;
            evt_level_q <= 1'b0;
            evt_cnt_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_dly_q    <= in_i;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            evt_id_q    <= evt_id_d;
            evt_level_q <= evt_level_d;
            evt_cnt_q   <= evt_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid_o = (state_q == S_BUSY);
    assign evt_id_o    = evt_id_q;
    assign evt_level_o = evt_level_q;
    assign pending_o   = pending_q;
    assign ovf_o       = ovf_q;
    assign evt_cnt_o   = evt_cnt_q;

endmodule
